// File: rtl/ahbmtx_l1_input_stage.sv
// Per-master input stage of the L1 AHB matrix. When the addressed output stage
// cannot take a transfer, this stage holds it and stalls the master. It also
// routes the owning output stage's data-phase response back to the master.
module ahbmtx_l1_input_stage #(
  parameter int ADDR_W = 32,
  parameter int PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [PROT_W-1:0] HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              REQ,
  output logic              SEL_O,
  output logic [ADDR_W-1:0] ADDR_O,
  output logic [1:0]        TRANS_O,
  output logic              WRITE_O,
  output logic [2:0]        SIZE_O,
  output logic [2:0]        BURST_O,
  output logic [PROT_W-1:0] PROT_O,
  output logic              MASTLOCK_O,
  output logic              HELD,
  input  logic              ACCEPT,
  input  logic              READYIN,
  input  logic [1:0]        RESPIN
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [PROT_W-1:0] prot;
    logic              mastlock;
  } ctrl_t;

  logic  trans_valid;
  logic  pend_q, pend_d;
  logic  dact_q, dact_d;
  ctrl_t hold_q, hold_d;
  ctrl_t live_ctrl;
  ctrl_t pres_ctrl;

  assign live_ctrl = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                       burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};

  // Only NONSEQ/SEQ are transfers; IDLE and BUSY pass straight through.
  assign trans_valid = HSELS & HREADYS & HTRANSS[1];

  always_comb begin
    // NOTE: every always_comb output takes a default first, so no path leaves it unassigned and no latch is inferred.
    hold_d = hold_q;
    pend_d = pend_q ? ~ACCEPT : (trans_valid & ~ACCEPT);
    dact_d = ACCEPT ? 1'b1 : ((dact_q & READYIN) ? 1'b0 : dact_q);
    if (trans_valid & ~ACCEPT & ~pend_q) hold_d = live_ctrl;
  end

  // NOTE: the hold registers are reset as well, so a discarded transfer never leaves stale controls behind.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= 1'b0;
      dact_q <= 1'b0;
      hold_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
      pend_q <= pend_d;
      dact_q <= dact_d;
      hold_q <= hold_d;
    end
  end

  assign pres_ctrl  = pend_q ? hold_q : live_ctrl;
  assign REQ        = pend_q | trans_valid;
  assign HELD       = pend_q;
  assign SEL_O      = pend_q | HSELS;
  assign ADDR_O     = pres_ctrl.addr;
  assign TRANS_O    = pres_ctrl.trans;
  assign WRITE_O    = pres_ctrl.write;
  assign SIZE_O     = pres_ctrl.size;
  assign BURST_O    = pres_ctrl.burst;
  assign PROT_O     = pres_ctrl.prot;
  assign MASTLOCK_O = pres_ctrl.mastlock;

  // Master-side response is combinational: a held transfer stalls, an owned data phase forwards.
  assign HREADYOUTS = pend_q ? 1'b0 : (dact_q ? READYIN : 1'b1);
  assign HRESPS     = (dact_q & ~pend_q) ? RESPIN : 2'b00;

endmodule
